// File: rtl/sram_read_arbiter.sv
// Two-requester round-robin arbiter for one synchronous-read SRAM port, with a bounded burst length.
// Define SRAM_RD_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module sram_read_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] sram_read_address,
   input  logic [DATA_WIDTH-1:0] sram_read_data,
   output logic                  arb_busy
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   logic                  owner_q, owner_d;
   logic                  last_owner_q, last_owner_d;
   logic [7:0]            burst_cnt_q, burst_cnt_d;
   logic [1:0]            rv_pend_q, rv_pend_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  pick1;

   always_comb begin
      pick1 = req1;
      if (req0 && req1) begin
`ifdef SRAM_RD_ARB_FIXED_PRIO_EN
         pick1 = 1'b0;
`else
         // burst_cnt of 0 means nobody was granted last cycle
         if (burst_cnt_q == 8'd0)
            pick1 = ~last_owner_q;
         else if (burst_cnt_q < MAX_B)
            pick1 = owner_q;
         else
            pick1 = ~owner_q;
`endif
      end
      gnt0 = ~reset & req0 & ~pick1;
      gnt1 = ~reset & req1 & pick1;
      sram_read_address = gnt0 ? addr0 : (gnt1 ? addr1 : addr_q);

      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      if (gnt0 || gnt1) begin
         owner_d      = gnt1;
         last_owner_d = gnt1;
         if ((gnt1 != owner_q) || (burst_cnt_q == 8'd0))
            burst_cnt_d = 8'd1;
         else if (burst_cnt_q < MAX_B)
            burst_cnt_d = burst_cnt_q + 8'd1;
      end else begin
         burst_cnt_d = 8'd0;
      end
      rv_pend_d = {gnt1, gnt0};
      addr_d    = sram_read_address;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         burst_cnt_q  <= 8'd0;
         rv_pend_q    <= 2'b00;
         addr_q       <= '0;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rv_pend_q    <= rv_pend_d;
         addr_q       <= addr_d;
      end
   end

   assign rvalid0  = rv_pend_q[0];
   assign rvalid1  = rv_pend_q[1];
   assign rdata0   = rv_pend_q[0] ? sram_read_data : '0;
   assign rdata1   = rv_pend_q[1] ? sram_read_data : '0;
   assign arb_busy = gnt0 | gnt1 | rvalid0 | rvalid1;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Scoreboard bench for sram_read_arbiter: directed grant patterns, read data returned through a queue.
module tb_sram_read_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [11:0] addr0, addr1;
   logic        gnt0, gnt1, rvalid0, rvalid1, arb_busy;
   logic [15:0] rdata0, rdata1;
   logic [11:0] sram_read_address;
   logic [15:0] sram_read_data = '0;

   typedef struct {bit id; logic [15:0] d;} exp_t;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [11:0] last_addr = '0;

   sram_read_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .sram_read_address(sram_read_address),
      .sram_read_data(sram_read_data), .arb_busy(arb_busy));

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [11:0] a);
      return {a, 4'h0} ^ 16'h3C5A;
   endfunction

   // synchronous-read SRAM model
   always @(posedge clk) sram_read_data <= memf(sram_read_address);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops one expected response per presented rvalid
   always @(negedge clk) begin
      if (!reset) begin
         chk("rvalid_excl", {31'd0, rvalid0 & rvalid1}, 32'd0);
         if (!rvalid0) chk("rdata0_gate", {16'd0, rdata0}, 32'd0);
         if (!rvalid1) chk("rdata1_gate", {16'd0, rdata1}, 32'd0);
         if (rvalid0 || rvalid1) begin
            if (q.size() == 0) begin
               chk("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rvalid_id", {30'd0, rvalid1, rvalid0}, e.id ? 32'd2 : 32'd1);
               chk("rdata", {16'd0, e.id ? rdata1 : rdata0}, {16'd0, e.d});
            end
         end
      end
   end

   // eg: 0 no grant, 1 gnt0, 2 gnt1
   task automatic step(input logic r0, input logic [11:0] a0, input logic r1,
                       input logic [11:0] a1, input int eg, input bit push = 1'b1);
      logic [11:0] ea;
      exp_t e;
      @(posedge clk); #1;
      req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
      #1;
      chk("gnt0", {31'd0, gnt0}, (eg == 1) ? 32'd1 : 32'd0);
      chk("gnt1", {31'd0, gnt1}, (eg == 2) ? 32'd1 : 32'd0);
      ea = (eg == 1) ? a0 : ((eg == 2) ? a1 : last_addr);
      chk("sram_addr", {20'd0, sram_read_address}, {20'd0, ea});
      last_addr = ea;
      if (eg != 0 && push) begin
         e.id = (eg == 2);
         e.d  = memf(ea);
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      last_addr = '0;
   endtask

   task automatic both(input int n, input int eg, input logic [11:0] base);
      for (int i = 0; i < n; i++) step(1, base + 12'(i), 1, base + 12'h100 + 12'(i), eg);
   endtask

   initial begin
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 12'h005; addr1 = 12'h006;
      #3;
      chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rst_rdata", {rdata1, rdata0}, 32'd0);
      chk("rst_addr", {20'd0, sram_read_address}, 32'd0);
      chk("rst_busy", {31'd0, arb_busy}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1 reset = 1'b0;

      // single requester 0
      step(1, 12'h005, 0, 12'h000, 1);
      step(0, 12'h000, 0, 12'h000, 0);
      step(0, 12'h000, 0, 12'h000, 0);

`ifdef SRAM_RD_ARB_FIXED_PRIO_EN
      do_reset();
      both(10, 1, 12'h200);
      step(0, 12'h000, 1, 12'h333, 2);
`else
      // continuous contention from reset
      do_reset();
      both(4, 1, 12'h010);
      both(4, 2, 12'h020);
      both(2, 1, 12'h030);
      step(0, 12'h000, 0, 12'h000, 0);

      // req1 alone, then req0 joins
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 12'h000, 1, 12'h040 + 12'(i), 2);
      both(1, 2, 12'h050);
      both(4, 1, 12'h060);
      both(1, 2, 12'h070);
      step(0, 12'h000, 0, 12'h000, 0);

      // req0 drops mid-burst
      do_reset();
      both(2, 1, 12'h080);
      step(0, 12'h000, 1, 12'h0F0, 2);
      both(1, 2, 12'h090);
      step(0, 12'h000, 0, 12'h000, 0);
`endif

      // reset while a read is in flight
      do_reset();
      step(1, 12'h0AB, 0, 12'h000, 1, 1'b0);
      @(posedge clk); #1;
      chk("inflight_rvalid0", {31'd0, rvalid0}, 32'd1);
      reset = 1'b1; req0 = 1'b0;
      #1;
      chk("rst_drop_rvalid0", {31'd0, rvalid0}, 32'd0);
      chk("rst_drop_busy", {31'd0, arb_busy}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      last_addr = '0;
      step(0, 12'h000, 0, 12'h000, 0);
      step(0, 12'h000, 0, 12'h000, 0);
      both(1, 1, 12'h0C0);
      step(0, 12'h000, 0, 12'h000, 0);
      step(0, 12'h000, 0, 12'h000, 0);

      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
